// File: rtl/de2_pio_gpio.sv
// de2_pio_gpio: parameterised Avalon-MM GPIO port.
// Per-pin direction, atomic set/clear of the output register, and
// synchronized inputs feeding edge capture with a maskable level irq.

// Per-pin input lane: synchronizer chain, previous-value flop, edge
// detect and the sticky edge-capture bit for one pin.
module de2_pio_gpio_lane #(
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = 0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin_i,    // raw, asynchronous pin value
  input  logic clr_i,    // write-1-to-clear for this capture bit
  output logic sync_o,   // synchronized pin value
  output logic cap_o     // captured-edge flag
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   cap_q,  cap_d;
  logic                   sync_in, rise, fall, edge_hit;

  assign sync_in = sync_q[SYNC_STAGES-1];

  // Shift the pin through the synchronizer, detect the selected edge and
  // update the capture bit; a fresh edge beats a same-cycle clear.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pin_i};
    prev_d = sync_in;
    rise   = sync_in & ~prev_q;
    fall   = ~sync_in & prev_q;
    case (EDGE_TYPE)
      0:       edge_hit = rise;
      1:       edge_hit = fall;
      default: edge_hit = rise | fall;
    endcase
    cap_d = (cap_q & ~clr_i) | edge_hit;
  end

  // Lane state; reset also flushes anything still in the synchronizer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      cap_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      cap_q  <= cap_d;
    end
  end

  assign sync_o = sync_in;
  assign cap_o  = cap_q;

endmodule

// Top level: register file, write decode, read mux and irq.
module de2_pio_gpio #(
  parameter int               WIDTH       = 18,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [WIDTH-1:0] RESET_DIR   = '1,
  parameter int               EDGE_TYPE   = 0,
  parameter int               SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe_port,
  output logic             irq
);

  localparam logic [2:0] A_DATA    = 3'd0;
  localparam logic [2:0] A_DIR     = 3'd1;
  localparam logic [2:0] A_IRQMASK = 3'd2;
  localparam logic [2:0] A_EDGECAP = 3'd3;
  localparam logic [2:0] A_OUTSET  = 3'd4;
  localparam logic [2:0] A_OUTCLR  = 3'd5;

  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] dir_q,  dir_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] clr_mask;
  logic [WIDTH-1:0] sync_in;
  logic [WIDTH-1:0] edgecap;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] rd_word;
  logic             wr;
  logic             unused_wd;

  assign wr = chipselect & ~write_n;
  assign wd = writedata[WIDTH-1:0];
  // Bits above WIDTH are deliberately ignored.
  assign unused_wd = ^writedata;

  // Write decode: next-state of the control registers and the
  // write-1-to-clear mask handed to the capture lanes.
  always_comb begin
    data_d   = data_q;
    dir_d    = dir_q;
    mask_d   = mask_q;
    clr_mask = '0;
    if (wr) begin
      case (address)
        A_DATA:    data_d   = wd;
        A_DIR:     dir_d    = wd;
        A_IRQMASK: mask_d   = wd;
        A_EDGECAP: clr_mask = wd;
        A_OUTSET:  data_d   = data_q | wd;
        A_OUTCLR:  data_d   = data_q & ~wd;
        default:   ;
      endcase
    end
  end

  // Control register state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= RESET_VALUE;
      dir_q  <= RESET_DIR;
      mask_q <= '0;
    end else begin
      data_q <= data_d;
      dir_q  <= dir_d;
      mask_q <= mask_d;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    de2_pio_gpio_lane #(
      .SYNC_STAGES (SYNC_STAGES),
      .EDGE_TYPE   (EDGE_TYPE)
    ) u_lane (
      .clk     (clk),
      .reset_n (reset_n),
      .pin_i   (in_port[i]),
      .clr_i   (clr_mask[i]),
      .sync_o  (sync_in[i]),
      .cap_o   (edgecap[i])
    );
  end

  // Zero-wait-state read mux; DATA shows driven pins from the output
  // register and the rest from the synchronized inputs.
  always_comb begin
    rd_word  = '0;
    case (address)
      A_DATA:    rd_word = (data_q & dir_q) | (sync_in & ~dir_q);
      A_DIR:     rd_word = dir_q;
      A_IRQMASK: rd_word = mask_q;
      A_EDGECAP: rd_word = edgecap;
      default:   rd_word = '0;
    endcase
    readdata = '0;
    readdata[WIDTH-1:0] = rd_word;
  end

  assign out_port = data_q;
  assign oe_port  = dir_q;
  assign irq      = |(edgecap & mask_q);

endmodule

// File: tb/tb_de2_pio_gpio.sv
// Self-checking bench for de2_pio_gpio: directed scenarios followed by
// random bus/pin traffic, all compared against a history-based model.
module tb_de2_pio_gpio;

  localparam int          W  = 18;
  localparam int          S  = 2;
  localparam int          ET = 0;
  localparam logic [W-1:0] RV = 18'h00155;

  logic          clk, reset_n, chipselect, write_n, irq;
  logic [2:0]    address;
  logic [31:0]   writedata, readdata;
  logic [W-1:0]  in_port, out_port, oe_port;

  de2_pio_gpio #(
    .WIDTH(W), .RESET_VALUE(RV), .RESET_DIR('1), .EDGE_TYPE(ET), .SYNC_STAGES(S)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .out_port(out_port), .oe_port(oe_port), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Model: registers plus the history of pin values seen at each edge
  // since reset. The synchronized value after edge n is the pin value
  // from S-1 edges earlier; anything before reset reads as 0.
  logic [W-1:0] m_data, m_dir, m_mask, m_cap;
  logic [W-1:0] hist [0:4095];
  int           cyc;

  function automatic logic [W-1:0] h(input int i);
    return (i < 0) ? '0 : hist[i];
  endfunction

  task automatic m_reset();
    m_data = RV; m_dir = '1; m_mask = '0; m_cap = '0; cyc = 0;
  endtask

  task automatic m_step(input bit w, input logic [2:0] a, input logic [31:0] d,
                        input logic [W-1:0] pin);
    logic [W-1:0] s_now, s_prev, ev, wd, clr;
    s_now  = h(cyc - S);
    s_prev = h(cyc - S - 1);
    if (ET == 0)      ev = s_now & ~s_prev;
    else if (ET == 1) ev = ~s_now & s_prev;
    else              ev = s_now ^ s_prev;
    wd  = d[W-1:0];
    clr = '0;
    if (w) begin
      case (a)
        3'd0: m_data = wd;
        3'd1: m_dir  = wd;
        3'd2: m_mask = wd;
        3'd3: clr    = wd;
        3'd4: m_data = m_data | wd;
        3'd5: m_data = m_data & ~wd;
        default: ;
      endcase
    end
    m_cap = (m_cap & ~clr) | ev;
    hist[cyc] = pin;
    cyc++;
  endtask

  function automatic logic [31:0] m_read(input logic [2:0] a);
    logic [W-1:0] s;
    s = h(cyc - S + 1 - 1);
    case (a)
      3'd0:    return {14'd0, (m_data & m_dir) | (s & ~m_dir)};
      3'd1:    return {14'd0, m_dir};
      3'd2:    return {14'd0, m_mask};
      3'd3:    return {14'd0, m_cap};
      default: return 32'd0;
    endcase
  endfunction

  task automatic check_all(input logic [2:0] a);
    chk("out_port", out_port, m_data);
    chk("oe_port",  oe_port,  m_dir);
    chk("irq",      irq,      |(m_cap & m_mask));
    chk("readdata", readdata, m_read(a));
  endtask

  // One bus cycle: drive inputs, take one edge, update model, check.
  task automatic tick(input bit w, input logic [2:0] a, input logic [31:0] d,
                      input logic [W-1:0] pin);
    chipselect = w; write_n = !w; address = a; writedata = d; in_port = pin;
    @(posedge clk);
    m_step(w, a, d, pin);
    #1;
    check_all(a);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] pin;
    logic [2:0]   a;
    int           hold;
    bit           w;

    reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = 3'd3;
    writedata = '0; in_port = '0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out", out_port, 18'h00155);
    chk("rst_oe",  oe_port,  18'h3FFFF);
    chk("rst_irq", irq,      1'b0);
    chk("rst_cap", readdata, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Set/clear
    tick(1, 3'd0, 32'h0000F, '0);
    tick(1, 3'd4, 32'h30000, '0);
    tick(1, 3'd5, 32'h00003, '0);
    chk("setclr_out", out_port, 18'h3000C);
    tick(0, 3'd4, 32'h0, '0);
    chk("outset_rd", readdata, 32'h0);
    tick(0, 3'd5, 32'h0, '0);
    chk("outclr_rd", readdata, 32'h0);

    // Direction mux
    tick(1, 3'd1, 32'h000FF, '0);
    tick(1, 3'd0, 32'h3FFFF, '0);
    for (int k = 0; k < S; k++) tick(0, 3'd0, 32'h0, '0);
    chk("dirmux_rd", readdata, 32'h000FF);
    tick(0, 3'd0, 32'h0, 18'h3FF00);
    for (int k = 1; k < S; k++) tick(0, 3'd0, 32'h0, 18'h3FF00);
    chk("dirmux_in", readdata, 32'h3FFFF);

    // Rising-edge capture; pins back to 0 first, nothing may be caught
    tick(1, 3'd2, 32'h00004, '0);
    for (int k = 0; k < S + 2; k++) tick(1, 3'd3, 32'h3FFFF, '0);
    chk("pre_cap", readdata, 32'h0);
    tick(0, 3'd3, 32'h0, 18'h00004);
    for (int k = 1; k <= S; k++) begin
      tick(0, 3'd3, 32'h0, 18'h00004);
      if (k < S) chk("cap_early", readdata, 32'h0);
    end
    chk("cap_rise", readdata, 32'h4);
    chk("cap_irq",  irq, 1'b1);
    tick(1, 3'd3, 32'h4, 18'h00004);
    chk("clr_irq", irq, 1'b0);
    tick(0, 3'd3, 32'h0, '0);
    for (int k = 0; k < S + 2; k++) tick(0, 3'd3, 32'h0, '0);
    chk("fall_none", readdata, 32'h0);

    // Clear racing a fresh edge on the same bit
    tick(0, 3'd3, 32'h0, 18'h00004);
    for (int k = 0; k < S + 1; k++) tick(0, 3'd3, 32'h0, 18'h00004);
    chk("race_pre", readdata, 32'h4);
    tick(0, 3'd3, 32'h0, '0);
    for (int k = 0; k < S + 1; k++) tick(0, 3'd3, 32'h0, '0);
    tick(0, 3'd3, 32'h0, 18'h00004);
    for (int k = 1; k < S; k++) tick(0, 3'd3, 32'h0, 18'h00004);
    tick(1, 3'd3, 32'h4, 18'h00004);
    chk("race_cap", readdata, 32'h4);
    chk("race_irq", irq, 1'b1);
    tick(1, 3'd3, 32'h4, 18'h00004);
    chk("late_clr", irq, 1'b0);

    // Reset mid-operation
    tick(1, 3'd2, 32'h3, 18'h00003);
    for (int k = 0; k < S; k++) tick(0, 3'd3, 32'h0, 18'h00003);
    chk("mid_cap", readdata, 32'h3);
    chk("mid_irq", irq, 1'b1);
    for (int k = 0; k < S + 2; k++) tick(0, 3'd3, 32'h0, '0);
    #3;
    reset_n = 1'b0;
    #1;
    chk("mr_irq", irq, 1'b0);
    chk("mr_out", out_port, 18'h00155);
    chk("mr_oe",  oe_port,  18'h3FFFF);
    chk("mr_cap", readdata, 32'h0);
    #2;
    reset_n = 1'b1;
    m_reset();
    for (int k = 0; k < S + 3; k++) tick(0, 3'd3, 32'h0, '0);
    chk("post_cap", readdata, 32'h0);

    // Random traffic
    pin  = '0;
    hold = 0;
    for (int i = 0; i < 400; i++) begin
      if (hold == 0) begin
        pin  = W'($urandom);
        hold = $urandom_range(1, 5);
      end
      hold--;
      w = ($urandom_range(0, 1) == 1);
      a = 3'($urandom_range(0, 7));
      tick(w, a, $urandom, pin);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/de2_pio_gpio.md
# de2_pio_gpio

Parametrised general-purpose I/O port on the Avalon-MM bus. It succeeds the fixed 18-bit output-only LED PIO with these changes:
- WIDTH is configurable.
- Each pin has a direction bit.
- Set and clear write strobes allow atomic bit updates.
- Inputs pass through a synchronizer and feed edge capture with a maskable interrupt to the Nios II.

One instance sits per board I/O group (LEDs, switches, keys, headers) in the system.

## Interface
Parameters:
- WIDTH, 18: number of pins; legal range 1..32.
- RESET_VALUE, 0: reset value of the output data register (WIDTH bits).
- RESET_DIR, all ones: reset value of the direction register; 1 = output.
- EDGE_TYPE, 0: capture mode; 0 = rising, 1 = falling, 2 = any edge.
- SYNC_STAGES, 2: depth of the input synchronizer flops; legal range 2..4.

Ports:
- clk  in  1  system clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  3  register word select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data; bits above WIDTH are ignored.
- readdata  out  32  read data; bits above WIDTH read 0.
- in_port  in  WIDTH  pin input values (asynchronous to clk).
- out_port  out  WIDTH  output data register value.
- oe_port  out  WIDTH  direction register; 1 = drive the pin.
- irq  out  1  level interrupt, active high.

## Operation
- Register map (word address). A write takes effect when chipselect=1 and write_n=0.
  - 0 DATA. Write loads data_out. Read returns, per bit, data_out where dir=1 and the synchronized input where dir=0.
  - 1 DIR. Read/write direction register.
  - 2 IRQMASK. Read/write, reset 0.
  - 3 EDGECAP. Read returns captured edges. Writing a 1 clears that bit; writing a 0 leaves it unchanged.
  - 4 OUTSET. Write ORs writedata into data_out. Reads return 0.
  - 5 OUTCLR. Write ANDs ~writedata into data_out. Reads return 0.
  - 6, 7 reserved. Writes are ignored; reads return 0.
- Reset values: data_out=RESET_VALUE, dir=RESET_DIR, irqmask=0, edgecap=0, all synchronizer flops 0. Therefore out_port=RESET_VALUE, oe_port=RESET_DIR, irq=0.
- Synchronizer: in_port passes through SYNC_STAGES flops to give sync_in. One further flop holds the previous value, prev_in.
- Edge detection per bit:
  - rise = sync_in & ~prev_in
  - fall = ~sync_in & prev_in
  - EDGE_TYPE selects rise, fall or rise|fall.
  - Edge detection runs on every bit regardless of dir.
- edgecap update each cycle:
  - edgecap <= (edgecap & ~clear_mask) | edge.
  - A set from a new edge wins over a simultaneous write-1-to-clear of the same bit.
- irq = |(edgecap & irqmask), decoded combinationally from registers. Writing IRQMASK or clearing EDGECAP deasserts irq in the cycle after the write edge.
- Reads are combinational with zero wait states and no side effects. Reading EDGECAP does not clear it.
- An asserted reset_n=0 at any time forces all registers to their reset values immediately, including any edge still in flight in the synchronizer.

## Timing
- Register writes are visible on out_port, oe_port and readdata after the clock edge that samples the write, i.e. 1 cycle.
- in_port to readable DATA value: SYNC_STAGES cycles.
- in_port edge to edgecap bit set: SYNC_STAGES+1 cycles. irq follows combinationally from edgecap.
- Back-to-back writes on consecutive cycles are legal; each one is applied in order.
- An input pulse shorter than one clk period may be missed. This is not an error.

## Test plan
- Reset: with WIDTH=18 and RESET_VALUE=18'h00155, hold reset_n low, then release. Check out_port=0x00155, oe_port=0x3FFFF, irq=0, EDGECAP read = 0.
- Set/clear: write DATA=0x0000F, then OUTSET=0x30000, then OUTCLR=0x00003. Check out_port=0x3000C after the third write. OUTSET/OUTCLR reads return 0.
- Direction mux: write DIR=0x000FF and DATA=0x3FFFF, drive in_port=0x00000. After SYNC_STAGES cycles, DATA read = 0x000FF.
- Rising-edge capture and irq: with EDGE_TYPE=0, IRQMASK=0x00004, toggle in_port[2] 0→1. EDGECAP bit 2 sets exactly SYNC_STAGES+1 cycles later and irq=1. A 1→0 transition captures nothing.
- Clear versus simultaneous edge: write EDGECAP=0x00004 in the same cycle that a new detected edge on bit 2 arrives. Bit 2 stays 1 and irq stays 1. A later clear with no new edge drops irq the next cycle.
- Reset mid-operation: with edgecap=0x3 and irq=1, pulse reset_n low for a partial cycle. irq, edgecap and out_port return to reset values immediately. No spurious capture occurs after release while in_port is held constant at 0.
